// File: rtl/fifo_pkg.sv
// Shared sizing constants and FSM encoding for the FIFO write arbiter.
package fifo_pkg;
    localparam int DEPTH         = 16;
    localparam int WIDTH         = 8;
    localparam int POINTER_WIDTH = 4;
    localparam int NUM_REQ       = 4;
    localparam int ID_WIDTH      = 2;
    localparam int BURST_LEN     = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_arb_pick.sv
// Combinational round-robin picker: nearest requester after last_grant, wrapping at NUM_REQ.
module rr_arb_pick #(
    parameter int NUM_REQ  = fifo_pkg::NUM_REQ,
    parameter int ID_WIDTH = fifo_pkg::ID_WIDTH
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic                valid,
    output logic [ID_WIDTH-1:0] winner
);
    int w_best;
    int w_dist;

    // Distance 0 is the producer right after last_grant; the smallest distance wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                valid  = 1'b1;
                winner = ID_WIDTH'(i);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates NUM_REQ producers onto one FIFO write port in bursts of up to BURST_LEN words,
// with a one-cycle IDLE bubble between bursts and a registered write strobe.
module fifo_wr_arbiter #(
    parameter int DEPTH         = fifo_pkg::DEPTH,
    parameter int WIDTH         = fifo_pkg::WIDTH,
    parameter int POINTER_WIDTH = fifo_pkg::POINTER_WIDTH,
    parameter int NUM_REQ       = fifo_pkg::NUM_REQ,
    parameter int ID_WIDTH      = fifo_pkg::ID_WIDTH,
    parameter int BURST_LEN     = fifo_pkg::BURST_LEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    input  logic [POINTER_WIDTH:0]     fifo_count,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wr_data,
    output logic [ID_WIDTH-1:0]        grant_id,
    output logic                       busy
);
    import fifo_pkg::*;

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int CNT_W  = POINTER_WIDTH + 2;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_WIDTH-1:0] r_grant_id;
    logic [ID_WIDTH-1:0] r_last_grant;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_wr_en;
    logic [WIDTH-1:0]    r_wr_data;

    logic                w_pick_vld;
    logic [ID_WIDTH-1:0] w_pick_id;
    logic [CNT_W-1:0]    w_used;
    logic                w_room;
    logic [NUM_REQ-1:0]  w_ack;
    logic                w_acked;
    logic                w_last_beat;
    logic                w_exit;

    rr_arb_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req        (req),
        .last_grant (r_last_grant),
        .valid      (w_pick_vld),
        .winner     (w_pick_id)
    );

    // space > 0 is evaluated as fifo_count + fifo_wr_en < DEPTH, which cannot underflow.
    assign w_used      = CNT_W'(fifo_count) + CNT_W'(r_wr_en);
    assign w_room      = (w_used < CNT_W'(DEPTH));
    assign w_acked     = |w_ack;
    assign w_last_beat = (r_beat_cnt == BEAT_W'(BURST_LEN - 1));

    always_comb begin
        w_ack = '0;
        if ((r_state == ST_BURST) && req[r_grant_id] && w_room && !fifo_full)
            w_ack[r_grant_id] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld)
                    w_state_nxt = ST_BURST;
            end
            ST_BURST: begin
                if (!req[r_grant_id] || (w_acked && w_last_beat)) begin
                    w_state_nxt = ST_IDLE;
                    w_exit      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Async reset also kills a write strobe already registered for the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_id   <= '0;
            r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_pick_vld) begin
                r_grant_id <= w_pick_id;
                r_beat_cnt <= '0;
            end else if (w_acked) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
            if (w_exit)
                r_last_grant <= r_grant_id;
            r_wr_en <= w_acked;
            if (w_acked)
                r_wr_data <= req_data[int'(r_grant_id)*WIDTH +: WIDTH];
        end
    end

    assign ack          = w_ack;
    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state == ST_BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed corner scenarios followed by randomised traffic.
module tb_fifo_wr_arbiter;
    localparam int DEPTH     = 16;
    localparam int WIDTH     = 8;
    localparam int PW        = 4;
    localparam int NUM_REQ   = 4;
    localparam int IDW       = 2;
    localparam int BURST_LEN = 4;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic [PW:0]              fifo_count;
    logic                     fifo_full;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_wr_data;
    logic [IDW-1:0]           grant_id;
    logic                     busy;

    fifo_wr_arbiter #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .POINTER_WIDTH(PW),
        .NUM_REQ(NUM_REQ), .ID_WIDTH(IDW), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        int               c;
    } exp_t;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    logic [WIDTH-1:0] pq [NUM_REQ][$];
    exp_t             exp_q[$];
    int               ack_log[$];
    int               dut_grants[$];
    logic [NUM_REQ-1:0] pause;
    int               fcnt;
    bit               rnd;
    bit               rd_on;
    int               m_owner;
    int               m_last;
    int               m_beats;
    bit               m_wr;
    bit               prev_busy;
    logic [NUM_REQ-1:0] ack_s;
    logic             wr_s;
    logic [WIDTH-1:0] mon_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = (pq[i].size() > 0) && !pause[i];
            req_data[i*WIDTH +: WIDTH] = (pq[i].size() > 0) ? pq[i][0] : '0;
        end
        fifo_count = (PW+1)'(fcnt);
    endtask

    // Reference model: one producer owns the port; words flow while room exists; bursts end
    // after BURST_LEN words or when the owner withdraws, then the next owner is found
    // by scanning forward from the previous owner.
    task automatic model_eval();
        logic [NUM_REQ-1:0] e_ack;
        int space;
        e_ack = '0;
        ack_s = ack;
        wr_s  = fifo_wr_en;
        if (m_owner >= 0) begin
            space = DEPTH - int'(fifo_count) - (m_wr ? 1 : 0);
            if (req[m_owner] && space > 0 && !fifo_full) e_ack[m_owner] = 1'b1;
        end
        chk("ack", ack, e_ack);
        chk("busy", busy, m_owner >= 0);
        if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
        if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
        prev_busy = busy;
        if (ack != 0) ack_log.push_back(cyc);
        if (m_owner < 0) begin
            for (int k = 1; k <= NUM_REQ && m_owner < 0; k++) begin
                if (req[(m_last + k) % NUM_REQ]) begin
                    m_owner = (m_last + k) % NUM_REQ;
                    m_beats = 0;
                end
            end
        end else begin
            if (e_ack != 0) begin
                exp_q.push_back('{d: pq[m_owner][0], c: cyc + 1});
                m_beats++;
            end
            if (!req[m_owner] || m_beats == BURST_LEN) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        m_wr = (e_ack != 0);
    endtask

    task automatic step();
        int rd;
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (ack_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        rd = 0;
        if (rd_on && fcnt > 0 && $urandom_range(1, 0) == 1) rd = 1;
        if (rnd) begin
            fifo_full = ($urandom_range(7, 0) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(15, 0) == 0) pause[i] = ~pause[i];
                if (pq[i].size() == 0 && $urandom_range(3, 0) == 0)
                    repeat ($urandom_range(6, 1)) pq[i].push_back(WIDTH'($urandom));
            end
        end
        if (wr_s) chk("no_overflow", fcnt < DEPTH, 1);
        fcnt = fcnt + (wr_s ? 1 : 0) - rd;
        if (fcnt > DEPTH) fcnt = DEPTH;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
        exp_q.delete();
        ack_log.delete();
        dut_grants.delete();
        pause     = '0;
        fcnt      = 0;
        fifo_full = 1'b0;
        rnd       = 1'b0;
        rd_on     = 1'b0;
        m_owner   = -1;
        m_last    = NUM_REQ - 1;
        m_beats   = 0;
        m_wr      = 1'b0;
        prev_busy = 1'b0;
        ack_s     = '0;
        wr_s      = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic fill(input int p, input int n, input logic [WIDTH-1:0] base);
        for (int k = 0; k < n; k++) pq[p].push_back(base + WIDTH'(k));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            mon_last = '0;
        end else if (fifo_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("write_expected", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", fifo_wr_data, e.d);
                chk("wr_latency", cyc, e.c);
                mon_last = e.d;
            end
        end else begin
            chk("wr_data_hold", fifo_wr_data, mon_last);
        end
    end

    initial begin
        int rise;
        int pending;
        reset     = 1'b1;
        pause     = '0;
        fcnt      = 0;
        fifo_full = 1'b0;
        rnd       = 1'b0;
        rd_on     = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", ack, 0);
        chk("reset_wr_en", fifo_wr_en, 0);
        chk("reset_wr_data", fifo_wr_data, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_busy", busy, 0);

        // Single producer, six words: 4-beat burst, one IDLE bubble, 2-beat burst.
        do_reset();
        fill(0, 6, 8'hA0);
        drive();
        rise = cyc;
        repeat (12) step();
        chk("A_ack_count", ack_log.size(), 6);
        for (int k = 0; k < ack_log.size() && k < 6; k++)
            chk("A_ack_cycle", ack_log[k] - rise, (k < 4) ? k + 1 : k + 2);

        // Producers 0 and 2 held: grants alternate 0,2,0,2.
        do_reset();
        fill(0, 8, 8'h10);
        fill(2, 8, 8'h20);
        drive();
        repeat (25) step();
        chk("B_grant_count", dut_grants.size(), 4);
        for (int k = 0; k < dut_grants.size() && k < 4; k++)
            chk("B_grant_order", dut_grants[k], (k % 2 == 0) ? 0 : 2);

        // Nearly full FIFO: one word fits, then stall until occupancy drops.
        do_reset();
        fcnt = 15;
        fill(1, 2, 8'h55);
        drive();
        repeat (8) step();
        chk("C_one_ack", ack_log.size(), 1);
        chk("C_busy_stalled", busy, 1);
        fcnt = 14;
        drive();
        repeat (8) step();
        chk("C_second_ack", ack_log.size(), 2);

        // fifo_full, then count==DEPTH: nobody acked while a grant is held.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) fill(i, 4, 8'(8'h40 + 8'(i*16)));
        fifo_full = 1'b1;
        drive();
        repeat (6) step();
        chk("D_full_no_ack", ack_log.size(), 0);
        chk("D_full_busy", busy, 1);
        fifo_full = 1'b0;
        fcnt = DEPTH;
        drive();
        repeat (6) step();
        chk("D_count_no_ack", ack_log.size(), 0);
        chk("D_count_busy", busy, 1);
        fcnt = 0;
        drive();
        repeat (30) step();
        chk("D_drained", ack_log.size(), 16);

        // Producer 0 withdraws after 2 beats while producer 3 waits.
        do_reset();
        fill(0, 5, 8'h70);
        fill(3, 2, 8'h30);
        drive();
        for (int t = 0; t < 20 && ack_log.size() < 2; t++) step();
        chk("E_two_beats", ack_log.size(), 2);
        pause[0] = 1'b1;
        drive();
        repeat (12) step();
        pause[0] = 1'b0;
        drive();
        repeat (12) step();
        chk("E_grant_count", dut_grants.size(), 3);
        for (int k = 0; k < dut_grants.size() && k < 3; k++)
            chk("E_grant_order", dut_grants[k], (k == 1) ? 3 : 0);

        // Reset during a burst with a write registered for the next cycle.
        do_reset();
        fill(0, 6, 8'hC0);
        drive();
        for (int t = 0; t < 20 && ack_log.size() < 2; t++) step();
        chk("F_inflight_wr_en", fifo_wr_en, 1);
        reset = 1'b1;
        #1;
        chk("F_reset_drops_write", fifo_wr_en, 0);
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) fill(i, 2, 8'(8'hD0 + 8'(i*4)));
        drive();
        repeat (20) step();
        chk("F_first_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);

        // Random traffic with reads, fifo_full glitches and producer withdrawals.
        do_reset();
        rnd   = 1'b1;
        rd_on = 1'b1;
        repeat (3000) step();
        rnd       = 1'b0;
        pause     = '0;
        fifo_full = 1'b0;
        drive();
        pending = 1;
        for (int t = 0; t < 800 && pending != 0; t++) begin
            step();
            pending = exp_q.size() + (busy ? 1 : 0);
            for (int i = 0; i < NUM_REQ; i++) pending += pq[i].size();
        end
        chk("R_drain_complete", pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be: DEPTH, default 16, FIFO capacity in words.
REQ-002 WIDTH, default 8, data word width.
REQ-003 POINTER_WIDTH, default 4, log2(DEPTH).
REQ-004 NUM_REQ, default 4, number of producers.
REQ-005 ID_WIDTH, default 2, log2(NUM_REQ).
REQ-006 BURST_LEN, default 4, maximum words per grant.
REQ-007 Ports SHALL be (reset is asynchronous, active-high; clock is clk):
  clk  in  1  clock, rising edge
  reset  in  1  asynchronous active-high reset
  req  in  NUM_REQ  per-producer write request; level held until acked
  req_data  in  NUM_REQ*WIDTH  producer i word at bits [i*WIDTH +: WIDTH]
  ack  out  NUM_REQ  one-hot; word of producer i accepted at this edge
  fifo_count  in  POINTER_WIDTH+1  current occupancy from the downstream FIFO
  fifo_full  in  1  downstream FIFO full flag
  fifo_wr_en  out  1  registered write strobe to FIFO
  fifo_wr_data  out  WIDTH  registered write data to FIFO
  grant_id  out  ID_WIDTH  index of the producer currently owning the burst
  busy  out  1  high while state is BURST

Function
REQ-008 The FSM SHALL have two states: IDLE and BURST.
REQ-009 In IDLE with any req bit set, the block SHALL select the winner round-robin, searching from last_grant+1 modulo NUM_REQ. It SHALL latch the winner into grant_id, clear beat_cnt and move to BURST; ack stays 0 in the IDLE cycle.
REQ-010 Space SHALL be computed as DEPTH - fifo_count - fifo_wr_en.
REQ-011 In BURST, ack[grant_id] SHALL be asserted combinationally when req[grant_id]=1, space>0 and fifo_full=0.
REQ-012 On an acked edge, fifo_wr_en<=1, fifo_wr_data<=the granted word, and beat_cnt increments. Otherwise fifo_wr_en<=0 and fifo_wr_data holds its value.
REQ-013 Latency SHALL be: first ack at the earliest one cycle after req rises; fifo_wr_en one cycle after each ack.
REQ-014 If space==0 or fifo_full=1, BURST SHALL stall: no ack, beat_cnt held, grant retained indefinitely.
REQ-015 BURST SHALL return to IDLE on the edge that acks beat BURST_LEN, or in any cycle where req[grant_id]=0. On either exit, last_grant<=grant_id.
REQ-016 Non-granted producers SHALL never see ack; at most one ack bit SHALL be set per cycle.
REQ-017 A bubble of exactly one IDLE cycle SHALL occur between consecutive bursts.
REQ-018 Round-robin order SHALL wrap from NUM_REQ-1 back to 0.
REQ-019 Producers SHALL NOT change req_data while req is set and not yet acked; the block does not check this.
REQ-020 fifo_count is never written by this block; reads on the FIFO side only increase space, so the space check is conservative.

Reset
REQ-021 On reset the block SHALL set: state=IDLE, ack=0, fifo_wr_en=0, fifo_wr_data=0, grant_id=0, busy=0, beat_cnt=0, last_grant=NUM_REQ-1 (producer 0 wins first).
REQ-022 Reset mid-burst SHALL drop any registered in-flight write; no write strobe is issued after reset asserts.

Structure
REQ-023 A shared package fifo_pkg SHALL hold: DEPTH, WIDTH, POINTER_WIDTH, NUM_REQ, ID_WIDTH, BURST_LEN and the state encoding constants.
REQ-024 Round-robin selection SHALL be a combinational sub-module rr_arb_pick, with inputs req and last_grant and outputs valid and winner index.
REQ-025 The block SHALL be a single clock domain with no memories.

Verification
REQ-026 req=0001, 6 words, fifo_count=0 -> 4 acks on consecutive cycles, 1 IDLE cycle, then 2 acks; fifo_wr_data shows the 6 words in order, each one cycle after its ack.
REQ-027 req=0101 held continuously -> bursts granted 0,2,0,2, each 4 beats, grant_id alternating.
REQ-028 fifo_count=15 entering BURST, no reads -> exactly 1 ack, then stall with busy=1; dropping fifo_count to 14 -> 1 more ack.
REQ-029 fifo_full=1 or fifo_count=16 -> no ack on any requester; busy=1 while granted.
REQ-030 req0 dropped after 2 beats while req3 pending -> IDLE, next grant 3, and last_grant advances to 0.
REQ-031 Reset asserted mid-burst at beat 2 with a write in flight -> fifo_wr_en=0 immediately; after release with req=1111 -> first grant is 0.
